hub75_scan: RTL and testbench

Row scheduler that sequences the HUB75 BCM engine across a full frame. Loads each row's pixels into one of two line-buffer banks through the framebuffer fill engine, then hands the filled bank to the BCM engine for shift/latch/blank. Fill of row n+1 overlaps display of row n. Sits between the framebuffer/line-buffer fill logic and the per-row BCM sequencer; also arbitrates the frame-buffer swap point.

---
 rtl/hub75_scan.sv | 206 ++++++++++++++++++++
 tb/tb_hub75_scan.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan.sv
// -----------------------------------------------------------------------------
// hub75_scan
//
// Row scheduler for a HUB75 panel. Two line-buffer banks are used as a
// ping-pong pair: the fill side loads row n+1 into the empty bank while the
// display side hands the bank that already holds row n to the BCM engine.
// The scheduler also picks the point at which the framebuffer may swap:
// the launch of the row-0 fill, so a whole frame always comes from one
// buffer.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   ctrl_run                      1 = keep scanning, 0 = drain, flush and stop
//   fill_row/fill_bank/fill_go    command to the line-buffer fill engine
//   fill_rdy                      fill engine idle/done (level)
//   bcm_row/bcm_row_first         row to display, and a flag for row 0
//   bcm_bank/bcm_go               bank to shift out, start pulse to BCM engine
//   bcm_rdy                       BCM engine idle (level)
//   frame_swap_req/frame_swap_ack framebuffer swap handshake
// -----------------------------------------------------------------------------
module hub75_scan #(
    parameter int N_ROWS     = 32,
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_run,
    output logic [LOG_N_ROWS-1:0] fill_row,
    output logic                  fill_bank,
    output logic                  fill_go,
    input  logic                  fill_rdy,
    output logic [LOG_N_ROWS-1:0] bcm_row,
    output logic                  bcm_row_first,
    output logic                  bcm_bank,
    output logic                  bcm_go,
    input  logic                  bcm_rdy,
    input  logic                  frame_swap_req,
    output logic                  frame_swap_ack
);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_GO   = 2'd1,
        F_WAIT = 2'd2
    } fill_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_GO   = 2'd1,
        D_WAIT = 2'd2
    } disp_state_e;

    localparam logic [LOG_N_ROWS-1:0] ROW_ONE = {{(LOG_N_ROWS-1){1'b0}}, 1'b1};

    fill_state_e           fstate_q, fstate_d;
    disp_state_e           dstate_q, dstate_d;
    logic [LOG_N_ROWS-1:0] frow_q, frow_d;
    logic [LOG_N_ROWS-1:0] drow_q, drow_d;
    logic                  fbank_q, fbank_d;
    logic                  dbank_q, dbank_d;
    logic [1:0]            full_q, full_d;
    logic                  f_first_q, f_first_d;
    logic                  ack_q, ack_d;

    logic                  fill_done;
    logic                  disp_done;
    logic                  flush;

    // ------------------------------------------------------------------
    // Fill side
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        fstate_d  = fstate_q;
        frow_d    = frow_q;
        fbank_d   = fbank_q;
        f_first_d = 1'b0;
        ack_d     = 1'b0;
        fill_done = 1'b0;
        unique case (fstate_q)
            F_IDLE: begin
                if (ctrl_run && !full_q[fbank_q] && fill_rdy) begin
                    fstate_d = F_GO;
                    // The ack is registered alongside the F_GO state so it
                    // lands in the same cycle as fill_go.
                    ack_d    = (frow_q == '0) && frame_swap_req;
                end
            end
            F_GO: begin
                fstate_d  = F_WAIT;
                f_first_d = 1'b1;
            end
            F_WAIT: begin
                // fill_rdy may still show the pre-go idle level in the first
                // wait cycle, so it is only trusted from the second cycle on.
                if (!f_first_q && fill_rdy) begin
                    fstate_d  = F_IDLE;
                    fill_done = 1'b1;
                    frow_d    = frow_q + ROW_ONE;
                    fbank_d   = ~fbank_q;
                end
            end
            default: fstate_d = F_IDLE;
        endcase

        if (flush) begin
            frow_d  = '0;
            fbank_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display side
    // ------------------------------------------------------------------
    always_comb begin
        dstate_d  = dstate_q;
        drow_d    = drow_q;
        dbank_d   = dbank_q;
        disp_done = 1'b0;
        unique case (dstate_q)
            D_IDLE: begin
                if (ctrl_run && full_q[dbank_q] && bcm_rdy) begin
                    dstate_d = D_GO;
                end
            end
            D_GO: begin
                dstate_d = D_WAIT;
            end
            D_WAIT: begin
                if (bcm_rdy) begin
                    dstate_d  = D_IDLE;
                    disp_done = 1'b1;
                    drow_d    = drow_q + ROW_ONE;
                    dbank_d   = ~dbank_q;
                end
            end
            default: dstate_d = D_IDLE;
        endcase

        if (flush) begin
            drow_d  = '0;
            dbank_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bank occupancy. Fill only completes into an empty bank and display
    // only releases a full one, so the set and clear never hit one bit in
    // the same cycle.
    // ------------------------------------------------------------------
    assign flush = !ctrl_run && (fstate_q == F_IDLE) && (dstate_q == D_IDLE);

    always_comb begin
        full_d = full_q;
        if (fill_done) begin
            full_d[fbank_q] = 1'b1;
        end
        if (disp_done) begin
            full_d[dbank_q] = 1'b0;
        end
        if (flush) begin
            full_d = 2'b00;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate_q  <= F_IDLE;
            dstate_q  <= D_IDLE;
            frow_q    <= '0;
            drow_q    <= '0;
            fbank_q   <= 1'b0;
            dbank_q   <= 1'b0;
            full_q    <= 2'b00;
            f_first_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            fstate_q  <= fstate_d;
            dstate_q  <= dstate_d;
            frow_q    <= frow_d;
            drow_q    <= drow_d;
            fbank_q   <= fbank_d;
            dbank_q   <= dbank_d;
            full_q    <= full_d;
            f_first_q <= f_first_d;
            ack_q     <= ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of registered state. Row/bank only change on
    // an operation's exit, so they are held for the whole GO/WAIT span.
    // ------------------------------------------------------------------
    assign fill_go        = (fstate_q == F_GO);
    assign fill_row       = frow_q;
    assign fill_bank      = fbank_q;
    assign bcm_go         = (dstate_q == D_GO);
    assign bcm_row        = drow_q;
    assign bcm_bank       = dbank_q;
    assign bcm_row_first  = (drow_q == '0);
    assign frame_swap_ack = ack_q;

endmodule

// File: tb/tb_hub75_scan.sv
// -----------------------------------------------------------------------------
// tb_hub75_scan
//
// Directed bench for hub75_scan with N_ROWS=4. Simple fill and BCM engine
// models answer the go pulses after a programmable latency; a monitor logs
// every go/ack pulse with its cycle number, and each test compares the log
// and the outputs against hand-derived cycle numbers and row/bank values.
// -----------------------------------------------------------------------------
module tb_hub75_scan;

    localparam int N_ROWS = 4;

    typedef struct packed {
        int         cyc;
        logic [1:0] row;
        logic       bank;
        logic       first;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       ctrl_run;
    logic [1:0] fill_row;
    logic       fill_bank;
    logic       fill_go;
    logic       fill_rdy;
    logic [1:0] bcm_row;
    logic       bcm_row_first;
    logic       bcm_bank;
    logic       bcm_go;
    logic       bcm_rdy;
    logic       frame_swap_req;
    logic       frame_swap_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fill_lat = 3;
    int bcm_lat  = 20;
    int fill_cnt;
    int bcm_cnt;

    ev_t fill_q[$];
    ev_t bcm_q[$];
    int  ack_q[$];

    hub75_scan #(.N_ROWS(N_ROWS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_run       (ctrl_run),
        .fill_row       (fill_row),
        .fill_bank      (fill_bank),
        .fill_go        (fill_go),
        .fill_rdy       (fill_rdy),
        .bcm_row        (bcm_row),
        .bcm_row_first  (bcm_row_first),
        .bcm_bank       (bcm_bank),
        .bcm_go         (bcm_go),
        .bcm_rdy        (bcm_rdy),
        .frame_swap_req (frame_swap_req),
        .frame_swap_ack (frame_swap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine models: busy for <lat> cycles starting the cycle after go.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= 0;
            bcm_cnt  <= 0;
        end else begin
            if (fill_go)           fill_cnt <= fill_lat;
            else if (fill_cnt > 0) fill_cnt <= fill_cnt - 1;
            if (bcm_go)            bcm_cnt  <= bcm_lat;
            else if (bcm_cnt > 0)  bcm_cnt  <= bcm_cnt - 1;
        end
    end
    assign fill_rdy = (fill_cnt == 0);
    assign bcm_rdy  = (bcm_cnt == 0);

    // Pulse log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fill_go)        fill_q.push_back('{cyc, fill_row, fill_bank, 1'b0});
            if (bcm_go)         bcm_q.push_back('{cyc, bcm_row, bcm_bank, bcm_row_first});
            if (frame_swap_ack) ack_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic ev_t mk(input int c, input int row, input int bank, input int first);
        mk = '{c, 2'(row), 1'(bank), 1'(first)};
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        ctrl_run       = 1'b0;
        frame_swap_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        fill_q.delete();
        bcm_q.delete();
        ack_q.delete();
    endtask

    task automatic start_run(output int c0);
        @(negedge clk);
        #1;
        ctrl_run = 1'b1;
        c0 = cyc;
    endtask

    task automatic wait_bcm_go(input int row, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            #1;
            if (bcm_go && bcm_row == 2'(row)) found = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [9:0] got;
        rst_n          = 1'b0;
        ctrl_run       = 1'b0;
        frame_swap_req = 1'b0;
        repeat (2) @(negedge clk);
        got = {fill_go, bcm_go, frame_swap_ack, fill_row, fill_bank, bcm_row, bcm_bank, bcm_row_first};
        n_checks++;
        if (got !== 10'b00_0_00_0_00_0_1) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", got, 10'b0000000001);
        end
        do_reset();
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (fill_q.size() != 0 || bcm_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_go: got fill=%0d bcm=%0d pulses expected 0", fill_q.size(), bcm_q.size());
        end
        got = {fill_go, bcm_go, frame_swap_ack, fill_row, fill_bank, bcm_row, bcm_bank, bcm_row_first};
        n_checks++;
        if (got !== 10'b0000000001) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b expected %b", got, 10'b0000000001);
        end
    endtask

    // Compare the logs against expected tables.
    task automatic test_basic_pipeline();
        int  c0;
        ev_t ef[3];
        ev_t eb[2];
        do_reset();
        fill_lat = 3;
        bcm_lat  = 20;
        start_run(c0);
        repeat (35) @(negedge clk);
        #1;
        ef = '{mk(c0+1, 0, 0, 0), mk(c0+7, 1, 1, 0), mk(c0+30, 2, 0, 0)};
        eb = '{mk(c0+7, 0, 0, 1), mk(c0+30, 1, 1, 0)};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= fill_q.size()) begin
                n_fail++;
                $display("FAIL basic_fill[%0d]: got no pulse expected cyc=%0d", i, ef[i].cyc);
            end else if (fill_q[i] !== ef[i]) begin
                n_fail++;
                $display("FAIL basic_fill[%0d]: got cyc=%0d row=%0d bank=%0d expected cyc=%0d row=%0d bank=%0d",
                         i, fill_q[i].cyc, fill_q[i].row, fill_q[i].bank, ef[i].cyc, ef[i].row, ef[i].bank);
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= bcm_q.size()) begin
                n_fail++;
                $display("FAIL basic_bcm[%0d]: got no pulse expected cyc=%0d", i, eb[i].cyc);
            end else if (bcm_q[i] !== eb[i]) begin
                n_fail++;
                $display("FAIL basic_bcm[%0d]: got cyc=%0d row=%0d bank=%0d first=%0d expected cyc=%0d row=%0d bank=%0d first=%0d",
                         i, bcm_q[i].cyc, bcm_q[i].row, bcm_q[i].bank, bcm_q[i].first,
                         eb[i].cyc, eb[i].row, eb[i].bank, eb[i].first);
            end
        end
    endtask

    task automatic test_backpressure();
        int  c0;
        ev_t ef[3];
        do_reset();
        fill_lat = 3;
        bcm_lat  = 200;
        start_run(c0);
        repeat (215) @(negedge clk);
        #1;
        ef = '{mk(c0+1, 0, 0, 0), mk(c0+7, 1, 1, 0), mk(c0+210, 2, 0, 0)};
        n_checks++;
        if (fill_q.size() != 3) begin
            n_fail++;
            $display("FAIL bp_fill_count: got %0d expected 3", fill_q.size());
        end
        for (int i = 0; i < 3 && i < fill_q.size(); i++) begin
            n_checks++;
            if (fill_q[i] !== ef[i]) begin
                n_fail++;
                $display("FAIL bp_fill[%0d]: got cyc=%0d row=%0d bank=%0d expected cyc=%0d row=%0d bank=%0d",
                         i, fill_q[i].cyc, fill_q[i].row, fill_q[i].bank, ef[i].cyc, ef[i].row, ef[i].bank);
            end
        end
        n_checks++;
        if (bcm_q.size() != 2 || bcm_q[1] !== mk(c0+210, 1, 1, 0)) begin
            n_fail++;
            $display("FAIL bp_bcm_row1: got count=%0d expected row1 bcm_go at cyc=%0d", bcm_q.size(), c0+210);
        end
    endtask

    // Steady state: one bcm_go every 23 cycles, rows 0..3 repeating.
    task automatic test_wrap();
        int  c0;
        ev_t e;
        do_reset();
        fill_lat = 3;
        bcm_lat  = 20;
        start_run(c0);
        repeat (290) @(negedge clk);
        #1;
        n_checks++;
        if (bcm_q.size() < 13) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d bcm pulses expected at least 13", bcm_q.size());
        end
        for (int i = 0; i < 13 && i < bcm_q.size(); i++) begin
            e = mk(c0 + 7 + 23*i, i % 4, i % 2, (i % 4 == 0) ? 1 : 0);
            n_checks++;
            if (bcm_q[i] !== e) begin
                n_fail++;
                $display("FAIL wrap_bcm[%0d]: got cyc=%0d row=%0d bank=%0d first=%0d expected cyc=%0d row=%0d bank=%0d first=%0d",
                         i, bcm_q[i].cyc, bcm_q[i].row, bcm_q[i].bank, bcm_q[i].first, e.cyc, e.row, e.bank, e.first);
            end
        end
    endtask

    task automatic test_frame_swap();
        int c0;
        int ea[3];
        // Request held high: ack on every row-0 fill, including the first.
        do_reset();
        fill_lat       = 3;
        bcm_lat        = 20;
        frame_swap_req = 1'b1;
        start_run(c0);
        repeat (200) @(negedge clk);
        #1;
        ea = '{c0+1, c0+76, c0+168};
        n_checks++;
        if (ack_q.size() != 3) begin
            n_fail++;
            $display("FAIL swap_held_count: got %0d acks expected 3", ack_q.size());
        end
        for (int i = 0; i < 3 && i < ack_q.size(); i++) begin
            n_checks++;
            if (ack_q[i] != ea[i]) begin
                n_fail++;
                $display("FAIL swap_held[%0d]: got ack at cyc=%0d expected cyc=%0d", i, ack_q[i], ea[i]);
            end
        end

        // Request raised during the row-2 fill: ack waits for the next row 0.
        do_reset();
        start_run(c0);
        repeat (30) @(negedge clk);
        frame_swap_req = 1'b1;
        repeat (50) @(negedge clk);
        frame_swap_req = 1'b0;
        repeat (120) @(negedge clk);
        #1;
        n_checks++;
        if (ack_q.size() != 1 || ack_q[0] != c0 + 76) begin
            n_fail++;
            $display("FAIL swap_late: got %0d acks first at cyc=%0d expected 1 ack at cyc=%0d",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1, c0 + 76);
        end

        // No request: no ack.
        do_reset();
        start_run(c0);
        repeat (200) @(negedge clk);
        #1;
        n_checks++;
        if (ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL swap_none: got %0d acks expected 0", ack_q.size());
        end
    endtask

    task automatic test_stop_restart();
        int  c0;
        int  c1;
        int  bf;
        int  bb;
        bit  found;
        logic [6:0] got;
        do_reset();
        fill_lat = 3;
        bcm_lat  = 20;
        start_run(c0);
        wait_bcm_go(2, 100, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stop_reach_row2: got no row2 bcm_go expected one within 100 cycles");
        end
        ctrl_run = 1'b0;
        bf = fill_q.size();
        bb = bcm_q.size();
        // In flight: fill row3/bank1 and display row2/bank0 keep their values.
        repeat (3) @(negedge clk);
        #1;
        got = {fill_row, fill_bank, bcm_row, bcm_bank, bcm_row_first};
        n_checks++;
        if (got !== {2'd3, 1'b1, 2'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_inflight_hold: got %b expected %b", got, {2'd3, 1'b1, 2'd2, 1'b0, 1'b0});
        end
        repeat (37) @(negedge clk);
        #1;
        n_checks++;
        if (fill_q.size() != bf || bcm_q.size() != bb) begin
            n_fail++;
            $display("FAIL stop_no_go: got %0d fill / %0d bcm new pulses expected 0",
                     fill_q.size() - bf, bcm_q.size() - bb);
        end
        got = {fill_row, fill_bank, bcm_row, bcm_bank, bcm_row_first};
        n_checks++;
        if (got !== 7'b00_0_00_0_1) begin
            n_fail++;
            $display("FAIL stop_flush1: got %b expected %b", got, 7'b0000001);
        end

        // Restart: row 0 / bank 0 first, and bank 1 must be free again.
        ctrl_run = 1'b1;
        c1 = cyc;
        wait_bcm_go(1, 100, found);
        n_checks++;
        if (fill_q.size() < bf + 2 || fill_q[bf] !== mk(c1+1, 0, 0, 0) || fill_q[bf+1] !== mk(c1+7, 1, 1, 0)) begin
            n_fail++;
            $display("FAIL restart_fill: got %0d new fills expected row0/bank0 at cyc=%0d then row1/bank1 at cyc=%0d",
                     fill_q.size() - bf, c1+1, c1+7);
        end
        n_checks++;
        if (bcm_q.size() < bb + 1 || bcm_q[bb] !== mk(c1+7, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL restart_bcm: got %0d new bcm pulses expected row0/bank0/first at cyc=%0d",
                     bcm_q.size() - bb, c1+7);
        end

        // Second stop with fill row2/bank0 in flight: frow/fbank must flush too.
        ctrl_run = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        got = {fill_row, fill_bank, bcm_row, bcm_bank, bcm_row_first};
        n_checks++;
        if (got !== 7'b0000001) begin
            n_fail++;
            $display("FAIL stop_flush2: got %b expected %b", got, 7'b0000001);
        end
    endtask

    task automatic test_async_reset();
        int  c0;
        int  c1;
        int  bf;
        int  bb;
        bit  found;
        logic [9:0] got;
        do_reset();
        fill_lat = 3;
        bcm_lat  = 20;
        start_run(c0);
        wait_bcm_go(1, 100, found);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        n_checks++;
        if (!found || bcm_row !== 2'd1 || bcm_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got found=%0d row=%0d bank=%0d expected 1 1 1", found, bcm_row, bcm_bank);
        end
        rst_n = 1'b0;
        #1;
        got = {fill_go, bcm_go, frame_swap_ack, fill_row, fill_bank, bcm_row, bcm_bank, bcm_row_first};
        n_checks++;
        if (got !== 10'b0000000001) begin
            n_fail++;
            $display("FAIL areset_outputs: got %b expected %b", got, 10'b0000000001);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        c1 = cyc;
        bf = fill_q.size();
        bb = bcm_q.size();
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (fill_q.size() < bf + 1 || fill_q[bf] !== mk(c1+1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL areset_restart_fill: got %0d new fills expected row0/bank0 at cyc=%0d", fill_q.size() - bf, c1+1);
        end
        n_checks++;
        if (bcm_q.size() < bb + 1 || bcm_q[bb] !== mk(c1+7, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL areset_restart_bcm: got %0d new bcm pulses expected row0/bank0 at cyc=%0d", bcm_q.size() - bb, c1+7);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        ctrl_run       = 1'b0;
        frame_swap_req = 1'b0;
        test_reset();
        test_basic_pipeline();
        test_backpressure();
        test_wrap();
        test_frame_swap();
        test_stop_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
